// File: rtl/i2c_arb_pkg.sv
// Shared types for the I2C transaction arbiter: FSM states, the latched
// transaction descriptor and the watchdog width.
package i2c_arb_pkg;

    localparam int CNT_W = 12;

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BSY,
        RUN,
        CMPL
    } arb_state_t;

    typedef struct packed {
        logic [7:0]  addr;
        logic [23:0] data;
        logic [1:0]  nsend;
        logic [1:0]  nrecv;
    } i2c_desc_t;

    // A descriptor that neither sends nor receives would start an empty bus cycle.
    function automatic logic desc_legal(i2c_desc_t d);
        return (d.nsend != 2'd0) || (d.nrecv != 2'd0);
    endfunction

endpackage

// File: rtl/i2c_txn_arbiter_if.sv
// Requester-side and master-side signals of the arbiter bundled as one interface.
interface i2c_txn_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0][7:0]   req_addr;
    logic [NUM_REQ-1:0][23:0]  req_data;
    logic [NUM_REQ-1:0][1:0]   req_nsend;
    logic [NUM_REQ-1:0][1:0]   req_nrecv;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [23:0]               rsp_data;
    logic                      rsp_err;
    logic                      m_start;
    logic [7:0]                m_addr;
    logic [23:0]               m_data;
    logic [1:0]                m_nsend;
    logic [1:0]                m_nrecv;
    logic                      m_busy;
    logic [23:0]               m_rdata;

    // Arbiter view.
    modport slave (
        input  req, req_addr, req_data, req_nsend, req_nrecv, m_busy, m_rdata,
        output gnt, done, rsp_data, rsp_err, m_start, m_addr, m_data, m_nsend, m_nrecv
    );

    // Requesters plus master engine view.
    modport master (
        output req, req_addr, req_data, req_nsend, req_nrecv, m_busy, m_rdata,
        input  gnt, done, rsp_data, rsp_err, m_start, m_addr, m_data, m_nsend, m_nrecv
    );
endinterface

// File: rtl/i2c_rr_pick.sv
// Combinational rotating-priority picker: the search begins one past the last winner.
module i2c_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] win_o,
    output logic [IDX_W-1:0]   idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        win_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                win_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C master engine between NUM_REQ requesters,
// with descriptor latching, a one-cycle start pulse and a completion watchdog.
module i2c_txn_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 4095
) (
    input  logic             clk,
    input  logic             rst,
    i2c_txn_arbiter_if.slave bus
);

    localparam int               IDX_W = $clog2(NUM_REQ);
    localparam logic [CNT_W-1:0] TMO   = CNT_W'(TIMEOUT);

    arb_state_t         state_q;
    logic [IDX_W-1:0]   last_q;
    logic [IDX_W-1:0]   idx_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic [NUM_REQ-1:0] done_q;
    i2c_desc_t          desc_q;
    logic               m_start_q;
    logic               rsp_err_q;
    logic [23:0]        rsp_data_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [CNT_W-1:0]   cnt_d;

    logic [NUM_REQ-1:0] pick_win;
    logic [IDX_W-1:0]   pick_idx;
    i2c_desc_t          pick_desc;

    i2c_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_i  (bus.req),
        .last_i (last_q),
        .win_o  (pick_win),
        .idx_o  (pick_idx)
    );

    assign pick_desc = '{addr:  bus.req_addr[pick_idx],
                         data:  bus.req_data[pick_idx],
                         nsend: bus.req_nsend[pick_idx],
                         nrecv: bus.req_nrecv[pick_idx]};
    assign cnt_d = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            last_q     <= IDX_W'(NUM_REQ - 1);
            idx_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            desc_q     <= '0;
            m_start_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_data_q <= '0;
            cnt_q      <= '0;
        end else begin
            m_start_q <= 1'b0;
            done_q    <= '0;
            case (state_q)
                IDLE: begin
                    if (|bus.req) begin
                        gnt_q   <= pick_win;
                        idx_q   <= pick_idx;
                        desc_q  <= pick_desc;
                        state_q <= GRANT;
                    end
                end
                GRANT: begin
                    if (!desc_legal(desc_q)) begin
                        rsp_err_q <= 1'b1;
                        done_q    <= gnt_q;
                        state_q   <= CMPL;
                    end else begin
                        m_start_q <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    cnt_q   <= '0;
                    state_q <= WAIT_BSY;
                end
                WAIT_BSY: begin
                    if (cnt_q == TMO) begin
                        rsp_err_q <= 1'b1;
                        done_q    <= gnt_q;
                        state_q   <= CMPL;
                    end else begin
                        cnt_q <= cnt_d;
                        if (bus.m_busy) state_q <= RUN;
                    end
                end
                RUN: begin
                    // A completion seen on the watchdog's last cycle still counts as success.
                    if (!bus.m_busy) begin
                        rsp_data_q <= bus.m_rdata;
                        rsp_err_q  <= 1'b0;
                        done_q     <= gnt_q;
                        state_q    <= CMPL;
                    end else if (cnt_q == TMO) begin
                        rsp_err_q <= 1'b1;
                        done_q    <= gnt_q;
                        state_q   <= CMPL;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                CMPL: begin
                    last_q  <= idx_q;
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.rsp_data = rsp_data_q;
    assign bus.rsp_err  = rsp_err_q;
    assign bus.m_start  = m_start_q;
    assign bus.m_addr   = desc_q.addr;
    assign bus.m_data   = desc_q.data;
    assign bus.m_nsend  = desc_q.nsend;
    assign bus.m_nrecv  = desc_q.nrecv;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed bench for i2c_txn_arbiter: a scoreboard of expected completions is
// filled as requests are driven and drained as done pulses appear.
module tb_i2c_txn_arbiter;
    import i2c_arb_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    i2c_txn_arbiter_if #(.NUM_REQ(4)) ifa ();
    i2c_txn_arbiter_if #(.NUM_REQ(4)) ifb ();

    i2c_txn_arbiter #(.NUM_REQ(4), .TIMEOUT(4095)) dut   (.clk(clk), .rst(rst), .bus(ifa));
    i2c_txn_arbiter #(.NUM_REQ(4), .TIMEOUT(16))   dut_t (.clk(clk), .rst(rst), .bus(ifb));

    localparam logic [23:0] RKEY = 24'hB090F0;

    typedef struct {
        bit          b;
        int          idx;
        logic [7:0]  addr;
        logic [23:0] data;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   busy_len = 20;
    logic [23:0] exp_rsp_a = '0;

    // Master engine model for the default-timeout instance: data returned is
    // the latched payload XOR a fixed key, so payload latching is also checked.
    initial begin
        ifa.m_busy  = 1'b0;
        ifa.m_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst && ifa.m_start) begin
                ifa.m_busy = 1'b1;
                for (int i = 0; i < busy_len; i++) begin
                    @(negedge clk);
                    if (rst) break;
                end
                ifa.m_rdata = ifa.m_data ^ RKEY;
                ifa.m_busy  = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input bit b, input int idx, input logic [7:0] addr,
                        input logic [23:0] data, input bit err);
        exp_t e;
        e.b = b; e.idx = idx; e.addr = addr; e.data = data; e.err = err;
        sb.push_back(e);
    endtask

    task automatic set_desc(input bit b, input int i, input logic [7:0] addr,
                            input logic [23:0] data, input logic [1:0] ns, input logic [1:0] nr);
        if (b) begin
            ifb.req_addr[i] = addr; ifb.req_data[i] = data;
            ifb.req_nsend[i] = ns;  ifb.req_nrecv[i] = nr;
        end else begin
            ifa.req_addr[i] = addr; ifa.req_data[i] = data;
            ifa.req_nsend[i] = ns;  ifa.req_nrecv[i] = nr;
        end
    endtask

    // Waits (bounded) for the next done pulse, checks it against the scoreboard
    // and drops the served request. Also reports when m_start was first seen.
    task automatic wait_done(input bit b, input int cyc0, input int budget,
                             output int cyc, output int start_cyc, output bit saw_start);
        logic [3:0] d;
        logic       st;
        bit         prev;
        bit         got;
        exp_t       e;
        cyc = cyc0; start_cyc = -1; saw_start = 0; prev = 0; got = 0;
        while (!got && cyc < budget) begin
            @(negedge clk);
            cyc++;
            st = b ? ifb.m_start : ifa.m_start;
            if (st) begin
                if (!saw_start) start_cyc = cyc;
                saw_start = 1;
                chk("start_one_cycle", 32'(prev), 32'd0);
            end
            prev = st;
            d = b ? ifb.done : ifa.done;
            if (d != 4'd0) begin
                got = 1;
                chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("done_vec", 32'(d), 32'(1 << e.idx));
                    chk("gnt_at_done", 32'(b ? ifb.gnt : ifa.gnt), 32'(1 << e.idx));
                    chk("rsp_err", 32'(b ? ifb.rsp_err : ifa.rsp_err), 32'(e.err));
                    chk("rsp_data", 32'(b ? ifb.rsp_data : ifa.rsp_data), 32'(e.data));
                    chk("m_addr_held", 32'(b ? ifb.m_addr : ifa.m_addr), 32'(e.addr));
                    if (b) ifb.req[e.idx] = 1'b0;
                    else   ifa.req[e.idx] = 1'b0;
                    $display("txn dut=%s idx=%0d rsp_data=%h rsp_err=%0b cycles=%0d",
                             b ? "tmo16" : "dflt", e.idx,
                             b ? ifb.rsp_data : ifa.rsp_data,
                             b ? ifb.rsp_err : ifa.rsp_err, cyc);
                end
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $error("FAIL wait_done: no done within %0d cycles, required a done pulse", budget);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"},      32'(ifa.gnt), 32'd0);
        chk({tag, "_done"},     32'(ifa.done), 32'd0);
        chk({tag, "_m_start"},  32'(ifa.m_start), 32'd0);
        chk({tag, "_rsp_err"},  32'(ifa.rsp_err), 32'd0);
        chk({tag, "_rsp_data"}, 32'(ifa.rsp_data), 32'd0);
        chk({tag, "_m_addr"},   32'(ifa.m_addr), 32'd0);
        chk({tag, "_m_data"},   32'(ifa.m_data), 32'd0);
        chk({tag, "_m_ncnt"},   32'({ifa.m_nsend, ifa.m_nrecv}), 32'd0);
        chk({tag, "_state"},    32'(dut.state_q), 32'(IDLE));
    endtask

    int cyc, sc;
    bit ss;

    initial begin
        ifa.req = '0; ifa.req_addr = '0; ifa.req_data = '0; ifa.req_nsend = '0; ifa.req_nrecv = '0;
        ifb.req = '0; ifb.req_addr = '0; ifb.req_data = '0; ifb.req_nsend = '0; ifb.req_nrecv = '0;
        ifb.m_busy = 1'b0; ifb.m_rdata = 24'hDEAD00;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_outputs_zero("rst");
        chk("rst_b_gnt", 32'(ifb.gnt), 32'd0);
        chk("rst_b_rsp_data", 32'(ifb.rsp_data), 32'd0);

        // Single request on requester 2
        set_desc(0, 2, 8'h50, 24'hA1B2C3, 2'd3, 2'd3);
        exp_rsp_a = 24'h112233;
        push(0, 2, 8'h50, exp_rsp_a, 0);
        ifa.req[2] = 1'b1;
        wait_done(0, 0, 200, cyc, sc, ss);
        chk("single_start_T2", 32'(sc), 32'd2);

        // All four at once from reset, then requester 0 again
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            set_desc(0, i, 8'(8'h10 + i), 24'(24'h100000 * (i + 1) + 24'h0A0B), 2'(1 + i % 3), 2'(i % 2));
            push(0, i, 8'(8'h10 + i), 24'(24'h100000 * (i + 1) + 24'h0A0B) ^ RKEY, 0);
        end
        ifa.req = 4'hF;
        wait_done(0, 0, 200, cyc, sc, ss);
        chk("rr_first_start", 32'(sc), 32'd2);
        for (int k = 1; k < 4; k++) begin
            wait_done(0, 0, 200, cyc, sc, ss);
            chk("rr_b2b_start", 32'(sc), 32'd3);
        end
        set_desc(0, 0, 8'h7E, 24'h00C0DE, 2'd2, 2'd2);
        exp_rsp_a = 24'h00C0DE ^ RKEY;
        push(0, 0, 8'h7E, exp_rsp_a, 0);
        ifa.req[0] = 1'b1;
        wait_done(0, 0, 200, cyc, sc, ss);
        chk("rereq0_start", 32'(sc), 32'd3);

        // Illegal descriptor: no start, error at T+2, data unchanged
        repeat (2) @(negedge clk);
        set_desc(0, 1, 8'h22, 24'h555555, 2'd0, 2'd0);
        push(0, 1, 8'h22, exp_rsp_a, 1);
        ifa.req[1] = 1'b1;
        wait_done(0, 0, 50, cyc, sc, ss);
        chk("illegal_done_T2", 32'(cyc), 32'd2);
        chk("illegal_no_start", 32'(ss), 32'd0);

        // Descriptor change after grant has no effect
        repeat (2) @(negedge clk);
        set_desc(0, 2, 8'h50, 24'h0F1E2D, 2'd2, 2'd1);
        exp_rsp_a = 24'h0F1E2D ^ RKEY;
        push(0, 2, 8'h50, exp_rsp_a, 0);
        ifa.req[2] = 1'b1;
        @(negedge clk);
        chk("addr_gnt_T1", 32'(ifa.gnt), 32'h4);
        chk("addr_m_addr_T1", 32'(ifa.m_addr), 32'h50);
        ifa.req_addr[2] = 8'h60;
        ifa.req_data[2] = 24'hFFFFFF;
        wait_done(0, 1, 200, cyc, sc, ss);
        chk("addr_start_T2", 32'(sc), 32'd2);

        // Reset while in RUN, then requester 0 must win over 3
        repeat (2) @(negedge clk);
        busy_len = 100;
        set_desc(0, 1, 8'h33, 24'h123456, 2'd1, 2'd2);
        ifa.req[1] = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre_rst_in_run", 32'(dut.state_q), 32'(RUN));
        rst = 1'b1;
        ifa.req[1] = 1'b0;
        #1;
        chk_outputs_zero("midrst");
        chk("midrst_last", 32'(dut.last_q), 32'd3);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        busy_len = 20;
        repeat (2) @(negedge clk);
        set_desc(0, 0, 8'h41, 24'h0000AA, 2'd1, 2'd1);
        set_desc(0, 3, 8'h44, 24'h0000BB, 2'd1, 2'd1);
        push(0, 0, 8'h41, 24'h0000AA ^ RKEY, 0);
        push(0, 3, 8'h44, 24'h0000BB ^ RKEY, 0);
        ifa.req = 4'b1001;
        wait_done(0, 0, 200, cyc, sc, ss);
        chk("postrst_start", 32'(sc), 32'd2);
        wait_done(0, 0, 200, cyc, sc, ss);
        chk("postrst_second_start", 32'(sc), 32'd3);

        // Watchdog on the TIMEOUT=16 instance: master never goes busy
        repeat (2) @(negedge clk);
        set_desc(1, 0, 8'h11, 24'hABCDEF, 2'd1, 2'd0);
        set_desc(1, 1, 8'h12, 24'h010203, 2'd0, 2'd3);
        push(1, 0, 8'h11, 24'h000000, 1);
        push(1, 1, 8'h12, 24'h000000, 1);
        ifb.req = 4'b0011;
        wait_done(1, 0, 100, cyc, sc, ss);
        chk("tmo_latency", 32'(cyc), 32'd20);
        chk("tmo_started", 32'(ss), 32'd1);
        wait_done(1, 0, 100, cyc, sc, ss);
        chk("tmo_next_latency", 32'(cyc), 32'd21);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
